lfsr_job_scheduler: RTL

//  Shares one 8-bit LFSR sequence engine between N_REQ requesters. Each requester posts a job: tap mask and step count.

---
 rtl/lfsr_sched_pkg.sv | 27 ++
 rtl/lfsr_rr_arbiter.sv | 41 ++++
 rtl/lfsr_job_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_sched_pkg.sv
// Shared definitions for the LFSR job scheduler: state encoding, default
// timeout limits and the packed-bus slice helper.
package lfsr_sched_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_LAUNCH    = ST_LAUNCH,
      S_WAIT_BUSY = ST_WAIT_BUSY,
      S_RUN       = ST_RUN,
      S_RESP      = ST_RESP
   } sched_state_t;

   localparam int DEF_START_TO = 16;
   localparam int DEF_RUN_TO   = 512;

   // LSB position of requester k inside a bus packed k*w +: w.
   function automatic int slice_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/lfsr_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, returned as a one-hot grant plus its encoded index.
module lfsr_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IW-1:0]    o_idx,
   output logic             o_valid
);

   logic [2*N_REQ-1:0] w_rot_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [N_REQ:0]     w_seen;
   logic [N_REQ-1:0]   w_pick;
   logic [2*N_REQ-1:0] w_back_dbl;
   logic [IW-1:0]      w_idx_acc [N_REQ+1];

   // Rotate so the pointer position lands at bit 0, then fixed priority.
   assign w_rot_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot     = w_rot_dbl[N_REQ-1:0];
   assign w_seen[0] = 1'b0;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_prio
      assign w_pick[gi]     = w_rot[gi] & ~w_seen[gi];
      assign w_seen[gi + 1] = w_seen[gi] | w_rot[gi];
   end

   assign w_back_dbl = {{N_REQ{1'b0}}, w_pick} << i_ptr;
   assign o_gnt      = w_back_dbl[N_REQ-1:0] | w_back_dbl[2*N_REQ-1:N_REQ];
   assign o_valid    = |i_req;

   assign w_idx_acc[0] = '0;
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_enc
      assign w_idx_acc[gi + 1] = w_idx_acc[gi] | (o_gnt[gi] ? IW'(gi) : '0);
   end
   assign o_idx = w_idx_acc[N_REQ];

endmodule

// File: rtl/lfsr_job_scheduler.sv
// Shares one LFSR sequence engine between N_REQ requesters: round-robin
// grant, payload capture, start pulse, busy tracking with timeouts, response.
module lfsr_job_scheduler
   import lfsr_sched_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DWIDTH   = 8,
   parameter int START_TO = DEF_START_TO,
   parameter int RUN_TO   = DEF_RUN_TO
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DWIDTH-1:0] req_taps,
   input  logic [N_REQ*DWIDTH-1:0] req_seq,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DWIDTH-1:0]       rsp_num,
   output logic                    rsp_err,
   output logic                    eng_start,
   output logic [DWIDTH-1:0]       eng_taps,
   output logic [DWIDTH-1:0]       eng_seq,
   input  logic                    eng_busy,
   input  logic [DWIDTH-1:0]       eng_num
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(RUN_TO);
   localparam logic [TW-1:0] START_LIM = TW'(START_TO - 1);
   localparam logic [TW-1:0] RUN_LIM   = TW'(RUN_TO - 1);

   sched_state_t      r_state;
   sched_state_t      w_state_next;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_idx;
   logic [N_REQ-1:0]  r_gnt;
   logic [DWIDTH-1:0] r_taps;
   logic [DWIDTH-1:0] r_seq;
   logic              r_start;
   logic [N_REQ-1:0]  r_rsp_valid;
   logic [DWIDTH-1:0] r_rsp_num;
   logic              r_rsp_err;
   logic [TW-1:0]     r_timer;

   logic [TW-1:0]     w_timer_inc;
   logic              w_timeout;
   logic              w_finish;
   logic [N_REQ-1:0]  w_arb_gnt;
   logic [IW-1:0]     w_arb_idx;
   logic              w_arb_valid;
   logic [IW-1:0]     w_ptr_next;
   logic [DWIDTH-1:0] w_taps_arr [N_REQ];
   logic [DWIDTH-1:0] w_seq_arr  [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_taps_arr[gi] = req_taps[slice_lsb(gi, DWIDTH) +: DWIDTH];
      assign w_seq_arr[gi]  = req_seq[slice_lsb(gi, DWIDTH) +: DWIDTH];
   end

   lfsr_rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   // Saturating increment: the timer never wraps back to zero.
   assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;
   assign w_ptr_next  = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_timeout    = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_arb_valid) begin
               w_state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_next = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (eng_busy) begin
               w_state_next = S_RUN;
            end else if (w_timer_inc == START_LIM) begin
               w_timeout    = 1'b1;
               w_state_next = S_RESP;
            end
         end
         S_RUN: begin
            if (!eng_busy) begin
               w_finish     = 1'b1;
               w_state_next = S_RESP;
            end else if (w_timer_inc == RUN_LIM) begin
               w_timeout    = 1'b1;
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ptr       <= '0;
         r_idx       <= '0;
         r_gnt       <= '0;
         r_taps      <= '0;
         r_seq       <= '0;
         r_start     <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_num   <= '0;
         r_rsp_err   <= 1'b0;
         r_timer     <= '0;
      end else begin
         r_start     <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_arb_valid) begin
                  r_gnt   <= w_arb_gnt;
                  r_idx   <= w_arb_idx;
                  r_taps  <= w_taps_arr[w_arb_idx];
                  r_seq   <= w_seq_arr[w_arb_idx];
                  r_start <= 1'b1;
               end
            end
            S_LAUNCH: begin
               r_timer <= '0;
            end
            S_WAIT_BUSY, S_RUN: begin
               if (w_timeout) begin
                  r_rsp_valid <= r_gnt;
                  r_rsp_err   <= 1'b1;
                  r_rsp_num   <= '0;
               end else if (w_finish) begin
                  r_rsp_valid <= r_gnt;
                  r_rsp_num   <= eng_num;
               end
               if (r_state == S_WAIT_BUSY && eng_busy) begin
                  r_timer <= '0;
               end else begin
                  r_timer <= w_timer_inc;
               end
            end
            S_RESP: begin
               // Pointer moves past the owner so a re-raised request waits its turn.
               r_gnt <= '0;
               r_ptr <= w_ptr_next;
            end
            default: begin
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_num   = r_rsp_num;
   assign rsp_err   = r_rsp_err;
   assign eng_start = r_start;
   assign eng_taps  = r_taps;
   assign eng_seq   = r_seq;

endmodule
